// File: rtl/chipper_inject_ni_pkg.sv
// Shared flit layout for the CHIPPER router and its network interfaces.
// The router decodes the same field positions, so edit them only in this file.
package chipper_pkg;

  localparam int COORD_W   = 2;
  localparam int SEQ_W     = 4;
  localparam int PAYLOAD_W = 15;
  localparam int FLIT_W    = 32;
  localparam int STARVE_W  = 8;

  localparam int DST_X_MSB   = 31;
  localparam int DST_X_LSB   = 30;
  localparam int DST_Y_MSB   = 29;
  localparam int DST_Y_LSB   = 28;
  localparam int DST_Z_MSB   = 27;
  localparam int DST_Z_LSB   = 26;
  localparam int SRC_X_MSB   = 25;
  localparam int SRC_X_LSB   = 24;
  localparam int SRC_Y_MSB   = 23;
  localparam int SRC_Y_LSB   = 22;
  localparam int SRC_Z_MSB   = 21;
  localparam int SRC_Z_LSB   = 20;
  localparam int SEQ_MSB     = 19;
  localparam int SEQ_LSB     = 16;
  localparam int PAYLOAD_MSB = 15;
  localparam int PAYLOAD_LSB = 1;
  localparam int VALID_BIT   = 0;

  // Packed view of one flit.  The field order matches the bit positions above.
  typedef struct packed {
    logic [COORD_W-1:0]   dst_x;
    logic [COORD_W-1:0]   dst_y;
    logic [COORD_W-1:0]   dst_z;
    logic [COORD_W-1:0]   src_x;
    logic [COORD_W-1:0]   src_y;
    logic [COORD_W-1:0]   src_z;
    logic [SEQ_W-1:0]     seq;
    logic [PAYLOAD_W-1:0] payload;
    logic                 valid;
  } flit_t;

  function automatic flit_t make_flit(
    input logic [COORD_W-1:0]   dst_x,
    input logic [COORD_W-1:0]   dst_y,
    input logic [COORD_W-1:0]   dst_z,
    input logic [COORD_W-1:0]   src_x,
    input logic [COORD_W-1:0]   src_y,
    input logic [COORD_W-1:0]   src_z,
    input logic [SEQ_W-1:0]     seq,
    input logic [PAYLOAD_W-1:0] payload
  );
    flit_t f;
    f.dst_x   = dst_x;
    f.dst_y   = dst_y;
    f.dst_z   = dst_z;
    f.src_x   = src_x;
    f.src_y   = src_y;
    f.src_z   = src_z;
    f.seq     = seq;
    f.payload = payload;
    f.valid   = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/chipper_ni_fifo.sv
// Power-of-two circular flit queue for the injection NI.
// Only the pointers and the count are reset; the storage array is not.
module chipper_ni_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Both pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/chipper_inject_ni.sv
// PE-side injection NI for the 3D CHIPPER router: stamps and queues flits,
// drives them through the request/grant handshake and flags starvation.
module chipper_inject_ni
  import chipper_pkg::*;
#(
  parameter logic [1:0] X            = 2'b01,
  parameter logic [1:0] Y            = 2'b01,
  parameter logic [1:0] Z            = 2'b01,
  parameter int         DEPTH        = 4,
  parameter int         STARVE_LIMIT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [1:0]                 tx_dst_x,
  input  logic [1:0]                 tx_dst_y,
  input  logic [1:0]                 tx_dst_z,
  input  logic [14:0]                tx_payload,
  output logic [31:0]                PEOUT_NI,
  output logic                       inject_request,
  input  logic                       inject_grant,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       starved
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  flit_t                flit_in;
  logic [FLIT_W-1:0]    head;
  logic [SEQ_W-1:0]     seq_cnt;
  logic [STARVE_W-1:0]  starve_cnt;
  logic [STARVE_W-1:0]  starve_nxt;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (v == '1) ? v : v + STARVE_W'(1);
  endfunction

  assign tx_ready       = !full;
  assign inject_request = !empty;
  assign push           = tx_valid && !full;
  assign pop            = inject_request && inject_grant;
  assign flit_in        = make_flit(tx_dst_x, tx_dst_y, tx_dst_z, X, Y, Z,
                                    seq_cnt, tx_payload);

  // Raw storage can hold stale data; an empty queue must present an all-zero slot.
  assign PEOUT_NI = empty ? '0 : head;

  chipper_ni_fifo #(
    .DATA_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (flit_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt <= '0;
    end else if (push) begin
      seq_cnt <= seq_cnt + SEQ_W'(1);
    end
  end

  // The counter measures how long the current head has waited for a grant.
  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || empty) begin
      starve_nxt = '0;
    end else begin
      starve_nxt = sat_inc(starve_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      starved    <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      starved    <= (starve_nxt >= LIMIT);
    end
  end

endmodule

// File: tb/tb_chipper_inject_ni.sv
// Directed bench for chipper_inject_ni with a queue-based reference model.
module tb_chipper_inject_ni;

  localparam int DEPTH = 4;
  localparam int LIMIT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [1:0]  tx_dst_x = '0;
  logic [1:0]  tx_dst_y = '0;
  logic [1:0]  tx_dst_z = '0;
  logic [14:0] tx_payload = '0;
  logic [31:0] PEOUT_NI;
  logic        inject_request;
  logic        inject_grant = 1'b0;
  logic [2:0]  fifo_count;
  logic        starved;

  int nvec = 0;
  int nerr = 0;

  chipper_inject_ni #(
    .X(2'b01), .Y(2'b01), .Z(2'b01), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_dst_x       (tx_dst_x),
    .tx_dst_y       (tx_dst_y),
    .tx_dst_z       (tx_dst_z),
    .tx_payload     (tx_payload),
    .PEOUT_NI       (PEOUT_NI),
    .inject_request (inject_request),
    .inject_grant   (inject_grant),
    .fifo_count     (fifo_count),
    .starved        (starved)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of flits, a sequence number and a wait counter.
  logic [31:0] mq[$];
  int          mseq = 0;
  int          mwait = 0;
  bit          mstarved = 1'b0;
  bit          m_push;
  bit          m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mseq     = 0;
      mwait    = 0;
      mstarved = 1'b0;
    end else begin
      m_push = tx_valid && (mq.size() < DEPTH);
      m_pop  = inject_grant && (mq.size() != 0);
      if (m_pop || mq.size() == 0) mwait = 0;
      else if (mwait < 255) mwait = mwait + 1;
      mstarved = (mwait >= LIMIT);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back({tx_dst_x, tx_dst_y, tx_dst_z, 2'b01, 2'b01, 2'b01,
                      4'(mseq), tx_payload, 1'b1});
        mseq = (mseq + 1) % 16;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("tx_ready",       32'(tx_ready),       32'(mq.size() < DEPTH));
    chk("inject_request", 32'(inject_request), 32'(mq.size() != 0));
    chk("PEOUT_NI",       PEOUT_NI,            (mq.size() != 0) ? mq[0] : 32'h0);
    chk("fifo_count",     32'(fifo_count),     32'(mq.size()));
    chk("starved",        32'(starved),        32'(mstarved));
  end

  task automatic drv(input bit v, input logic [1:0] dx, input logic [1:0] dy,
                     input logic [1:0] dz, input logic [14:0] pl, input bit g);
    tx_valid     = v;
    tx_dst_x     = dx;
    tx_dst_y     = dy;
    tx_dst_z     = dz;
    tx_payload   = pl;
    inject_grant = g;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_req",   32'(inject_request), 32'd0);
    chk("rst_out",   PEOUT_NI, 32'h0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;

    // Single flit, exact encoding
    drv(1, 2'd1, 2'd0, 2'd2, 15'h1234, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    chk("single_flit", PEOUT_NI, 32'h4950_2469);
    chk("single_req",  32'(inject_request), 32'd1);
    drv(0, 0, 0, 0, 0, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    chk("single_drop", 32'(inject_request), 32'd0);
    chk("single_zero", PEOUT_NI, 32'h0);

    // Fill to full, overflow attempt, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(1, 2'(i), 2'd3, 2'd1, 15'(16'h0100 + i), 0);
      step();
    end
    chk("full_ready", 32'(tx_ready), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    drv(1, 2'd2, 2'd2, 2'd2, 15'h7fff, 0);
    step();
    chk("overflow_count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_seq",     32'(PEOUT_NI[19:16]), 32'(i));
      chk("drain_payload", 32'(PEOUT_NI[15:1]),  32'(16'h0100 + i));
      drv(0, 0, 0, 0, 0, 1);
      step();
    end
    drv(0, 0, 0, 0, 0, 0);
    chk("drain_empty", 32'(inject_request), 32'd0);

    // Sequence wrap over 17 flits
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drv(1, 2'd0, 2'd1, 2'd1, 15'(i * 3), 0);
      step();
      chk("wrap_seq", 32'(PEOUT_NI[19:16]), 32'(i % 16));
      drv(0, 0, 0, 0, 0, 1);
      step();
    end
    drv(0, 0, 0, 0, 0, 0);

    // Starvation after LIMIT ungranted cycles, cleared by one grant
    do_reset();
    drv(1, 2'd1, 2'd1, 2'd1, 15'h0abc, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < LIMIT - 1; i++) step();
    chk("starve_before", 32'(starved), 32'd0);
    step();
    chk("starve_rise", 32'(starved), 32'd1);
    chk("starve_head", PEOUT_NI, 32'h5550_1579);
    drv(0, 0, 0, 0, 0, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    chk("starve_clear", 32'(starved), 32'd0);

    // Simultaneous push and pop at occupancy 2
    do_reset();
    drv(1, 2'd3, 2'd0, 2'd0, 15'h0011, 0); step();
    drv(1, 2'd3, 2'd0, 2'd0, 15'h0022, 0); step();
    drv(1, 2'd3, 2'd0, 2'd0, 15'h0033, 1); step();
    drv(0, 0, 0, 0, 0, 0);
    chk("pp_count",   32'(fifo_count), 32'd2);
    chk("pp_head",    32'(PEOUT_NI[15:1]), 32'h0022);
    drv(0, 0, 0, 0, 0, 1); step();
    drv(0, 0, 0, 0, 0, 0);
    chk("pp_tail",    32'(PEOUT_NI[15:1]), 32'h0033);
    chk("pp_tailseq", 32'(PEOUT_NI[19:16]), 32'd2);

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1, 2'd2, 2'd1, 2'd0, 15'(i + 5), 0);
      step();
    end
    drv(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out",   PEOUT_NI, 32'h0);
    chk("arst_req",   32'(inject_request), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_ready", 32'(tx_ready), 32'd1);
    step();
    rst = 1'b0;
    drv(1, 2'd1, 2'd1, 2'd1, 15'h0001, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    chk("arst_seq0", PEOUT_NI, 32'h5550_0003);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/chipper_inject_ni.md
# chipper_inject_ni

Processing-element-side injection network interface for the 3D CHIPPER router, i.e. the transmitter end of the router's PE injection port. It accepts payload and destination requests from the local PE, builds 32-bit flits stamped with this node's source coordinates and a sequence number, and queues them. It then drives them into the router's PE input using the `inject_request`/`inject_grant` handshake. It also flags starvation when the bufferless router withholds a grant for too long.

## Interface
Parameters:
- `X`, default 2'b01: this node's x coordinate; must match the router instance.
- `Y`, default 2'b01: this node's y coordinate.
- `Z`, default 2'b01: this node's z coordinate.
- `DEPTH`, default 4: flit queue entries; must be a power of two, 2..16.
- `STARVE_LIMIT`, default 15: cycles of ungranted request before `starved` is raised; valid range 1..255.

Ports:
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_valid`  in  1  PE offers a flit.
- `tx_ready`  out  1  NI can accept; equals !full.
- `tx_dst_x`, `tx_dst_y`, `tx_dst_z`  in  2 each  destination coordinates.
- `tx_payload`  in  15  payload bits.
- `PEOUT_NI`  out  32  flit driven to the router's `PEIN`.
- `inject_request`  out  1  to router; high when the queue is non-empty.
- `inject_grant`  in  1  from router; head flit is consumed at this edge.
- `fifo_count`  out  $clog2(DEPTH)+1  occupancy.
- `starved`  out  1  request held for STARVE_LIMIT cycles without a grant.

## Operation
- Flit format:
  - [31:30] dst_x
  - [29:28] dst_y
  - [27:26] dst_z
  - [25:24] src_x
  - [23:22] src_y
  - [21:20] src_z
  - [19:16] seq
  - [15:1] payload
  - [0] valid (1)
- An all-zero word is an empty slot.
- Push:
  - Occurs when `tx_valid && tx_ready` at an edge.
  - The flit is assembled from the inputs, the parameters and `seq_cnt`, then written at the tail.
  - `seq_cnt` (4 bits) increments on each push and wraps 15 -> 0.
- Pop:
  - Occurs when `inject_request && inject_grant` at an edge; the head entry is removed.
  - A grant while `inject_request` is low is ignored: no pop, no error.
- `PEOUT_NI` is the head entry when the queue is non-empty, else 32'h0.
- `inject_request` = (count != 0). Once raised it stays high with an unchanged `PEOUT_NI` until granted. The head never changes without a grant.
- Self-addressed requests (dst == X,Y,Z) are injected normally; the router ejects them.
- Starvation counter (8 bits, saturating):
  - Clears on any pop or when the queue is empty.
  - Otherwise increments each cycle `inject_request` is high.
  - `starved` = (counter >= STARVE_LIMIT).
- Push and pop in the same cycle (queue non-empty, not full): occupancy unchanged, both pointers advance.
- Full: `tx_ready` low, so no push. A simultaneous pop frees a slot that is visible next cycle.
- Empty: `inject_request` low, so a grant has no effect. A push makes the flit visible on `PEOUT_NI` the next cycle.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, immediate, held while `rst`=1):
  - Pointers, count, `seq_cnt` and the starve counter go to 0.
  - `PEOUT_NI`=0, `inject_request`=0, `starved`=0, `fifo_count`=0, `tx_ready`=1.
- Reset mid-operation discards all queued flits. Sequence numbering restarts at 0.
- Push-to-request latency: 1 cycle (the edge that pushes into an empty queue raises `inject_request` after it).
- Grant-to-next-flit: 0 bubble cycles. After the popping edge `PEOUT_NI` shows the next entry in the same cycle, or 0 if the queue is now empty.
- `tx_ready`, `inject_request`, `PEOUT_NI` and `fifo_count` are combinational from registered state only. There are no combinational paths from `inject_grant` or `tx_valid` to any output.
- `starved` is registered and rises on the edge at which the counter reaches STARVE_LIMIT.

## Structure
- `chipper_pkg`:
  - Flit field position constants (`DST_X_MSB`, …, `VALID_BIT`).
  - `COORD_W` = 2, `SEQ_W` = 4, `PAYLOAD_W` = 15, `FLIT_W` = 32.
  - Shared with the router, so its routing logic decodes the same fields.
- Sub-module `chipper_ni_fifo`:
  - Parameterised synchronous FIFO with width FLIT_W and depth DEPTH.
  - Provides push/pop/full/empty/count and async reset.
  - Flit assembly, the sequence counter and the starvation monitor live in the top block.

## Test plan
- Reset, then a single push with dst (1,0,2) and payload 15'h1234. Next cycle `PEOUT_NI` = {2'b01,2'b00,2'b10,2'b01,2'b01,2'b01,4'h0,15'h1234,1'b1} and `inject_request`=1. A grant pops it and the request drops.
- Push 4 flits with no grant. `tx_ready`=0 and `fifo_count`=4. A 5th `tx_valid` is not accepted. Four grants pop the flits in order with seq 0..3.
- Push 17 flits, granting each. The seq fields run 0..15 then 0.
- Hold a request with `inject_grant`=0 and STARVE_LIMIT=15. `starved` rises after 15 cycles. One grant clears it the next cycle.
- Queue at 2, simultaneous push and grant. Count stays 2, the head advances, and the new flit is at the tail.
- Assert `rst` mid-stream with 3 flits queued. Outputs go to 0 immediately. After release the first push carries seq 0.
